apb_protocol_checker: RTL and testbench

//  Synthesisable, parametrised APB3/APB4 protocol monitor; a passive tap on one APB slave port.

---
 rtl/apb_chk_pkg.sv | 23 ++
 rtl/apb_chk_sat_cnt.sv | 26 ++
 rtl/apb_protocol_checker.sv | 162 ++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_chk_pkg.sv
// Shared types and constants for the APB protocol checker.
//   apb_chk_state_t : phase the checker expects at the next pclk edge
//   V_*             : bit positions inside the viol/sticky vectors
//   NUM_CHECKS      : width of the viol/sticky vectors
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_chk_state_t;

  localparam int NUM_CHECKS  = 7;

  localparam int V_SEL_DROP  = 0;
  localparam int V_SETUP_SEQ = 1;
  localparam int V_ADDR_CHG  = 2;
  localparam int V_WDATA_CHG = 3;
  localparam int V_EN_NO_SEL = 4;
  localparam int V_TIMEOUT   = 5;
  localparam int V_STRB_READ = 6;

endpackage

// File: rtl/apb_chk_sat_cnt.sv
// Saturating up-counter used for the checker's status counters.
//   pclk, preset_n : clock, asynchronous active-low reset
//   inc            : count one event this cycle (ignored once all-ones)
//   clr            : synchronous clear, wins over inc
//   cnt            : current count
module apb_chk_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3/APB4 protocol monitor tapped onto one slave port.
// Tracks the transfer phase, flags protocol violations as registered one-cycle
// pulses (viol) plus sticky bits, and keeps saturating status counters.
//   pclk, preset_n          : clock, asynchronous active-low reset
//   psel .. pslverr         : tapped APB signals (inputs only)
//   clr                     : synchronous clear of sticky bits and counters
//   viol / sticky           : violation pulses / accumulated violations
//   xfer_cnt, err_cnt,
//   slverr_cnt              : completed transfers, violating cycles, PSLVERR completions
//   busy                    : a transfer is in SETUP or ACCESS
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int MAX_WAIT   = 16,
  parameter int CHECK_STRB = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [AW-1:0]         paddr,
  input  logic [DW-1:0]         pwdata,
  input  logic [DW/8-1:0]       pstrb,
  input  logic [2:0]            pprot,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic                  clr,
  output logic [NUM_CHECKS-1:0] viol,
  output logic [NUM_CHECKS-1:0] sticky,
  output logic [CNT_W-1:0]      xfer_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      slverr_cnt,
  output logic                  busy
);

  localparam int SW = DW / 8;
  // Wait counter only needs to reach MAX_WAIT; it saturates there.
  localparam int WW = $clog2(MAX_WAIT + 2);

  apb_chk_state_t state_q, state_d;
  logic [WW-1:0]  wait_q, wait_d;

  logic [AW-1:0]  cap_addr_q;
  logic           cap_write_q;
  logic [2:0]     cap_prot_q;
  logic [DW-1:0]  cap_wdata_q;
  logic [SW-1:0]  cap_strb_q;

  logic                  capture, complete;
  logic                  addr_chg, wdata_chg;
  logic [NUM_CHECKS-1:0] viol_p0;

  always_comb begin
    addr_chg  = (paddr != cap_addr_q) || (pwrite != cap_write_q);
    wdata_chg = (pwdata != cap_wdata_q);
    if (CHECK_STRB != 0) begin
      addr_chg  = addr_chg  || (pprot != cap_prot_q);
      wdata_chg = wdata_chg || (pstrb != cap_strb_q);
    end
    wdata_chg = wdata_chg && pwrite;
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    capture  = 1'b0;
    complete = 1'b0;
    viol_p0  = '0;
    viol_p0[V_EN_NO_SEL] = penable && !psel;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          state_d = SETUP;
        end else if (psel && penable) begin
          viol_p0[V_SETUP_SEQ] = 1'b1;
        end
      end
      SETUP, ACCESS: begin
        if (!psel) begin
          viol_p0[V_SEL_DROP] = 1'b1;
          state_d = IDLE;
          wait_d  = '0;
        end else if (!penable) begin
          viol_p0[V_SETUP_SEQ] = 1'b1;
          if (state_q == SETUP) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
            wait_d  = '0;
          end
        end else begin
          viol_p0[V_ADDR_CHG]  = addr_chg;
          viol_p0[V_WDATA_CHG] = wdata_chg;
          if (pready) begin
            complete = 1'b1;
            state_d  = IDLE;
            wait_d   = '0;
          end else begin
            state_d = ACCESS;
            // wait_q is 0 in SETUP, so the first stalled edge yields 1.
            if (wait_q != WW'(MAX_WAIT)) wait_d = wait_q + WW'(1);
            // Fires only on the step into MAX_WAIT, hence once per transfer.
            if ((MAX_WAIT != 0) && (wait_q == WW'(MAX_WAIT - 1)))
              viol_p0[V_TIMEOUT] = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
    viol_p0[V_STRB_READ] = (CHECK_STRB != 0) && capture && !pwrite && (pstrb != '0);
  end

  // ---- stage boundary: phase tracking, capture and violation registers ----
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      cap_addr_q  <= '0;
      cap_write_q <= 1'b0;
      cap_prot_q  <= '0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
      viol        <= '0;
      sticky      <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (capture) begin
        cap_addr_q  <= paddr;
        cap_write_q <= pwrite;
        cap_prot_q  <= pprot;
        cap_wdata_q <= pwdata;
        cap_strb_q  <= pstrb;
      end
      viol   <= viol_p0;
      sticky <= clr ? '0 : (sticky | viol_p0);
    end
  end

  assign busy = (state_q != IDLE);

  apb_chk_sat_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
    .pclk(pclk), .preset_n(preset_n), .inc(complete), .clr(clr), .cnt(xfer_cnt)
  );

  apb_chk_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .pclk(pclk), .preset_n(preset_n), .inc(|viol_p0), .clr(clr), .cnt(err_cnt)
  );

  apb_chk_sat_cnt #(.CNT_W(CNT_W)) u_slverr_cnt (
    .pclk(pclk), .preset_n(preset_n), .inc(complete && pslverr), .clr(clr), .cnt(slverr_cnt)
  );

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Bench for apb_protocol_checker: two instances share one tapped bus,
// "a" with MAX_WAIT=4/CHECK_STRB=1 and "b" with MAX_WAIT=0/CHECK_STRB=0.
module tb_apb_protocol_checker;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite, pready, pslverr, clr;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [6:0]  viol_a, sticky_a, viol_b, sticky_b;
  logic [15:0] xfer_a, err_a, slv_a, xfer_b, err_b, slv_b;
  logic        busy_a, busy_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  apb_protocol_checker #(.AW(8), .DW(32), .MAX_WAIT(4), .CHECK_STRB(1), .CNT_W(16)) dut_a (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready),
    .pslverr(pslverr), .clr(clr), .viol(viol_a), .sticky(sticky_a), .xfer_cnt(xfer_a),
    .err_cnt(err_a), .slverr_cnt(slv_a), .busy(busy_a)
  );

  apb_protocol_checker #(.AW(8), .DW(32), .MAX_WAIT(0), .CHECK_STRB(0), .CNT_W(16)) dut_b (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready),
    .pslverr(pslverr), .clr(clr), .viol(viol_b), .sticky(sticky_b), .xfer_cnt(xfer_b),
    .err_cnt(err_b), .slverr_cnt(slv_b), .busy(busy_b)
  );

  typedef struct {
    bit        sel, en, wr;
    bit [7:0]  a;
    bit [31:0] d;
    bit [3:0]  s;
    bit [2:0]  p;
    bit        rdy, err;
  } bus_t;

  typedef struct {
    bus_t     b;
    bit [6:0] ev;   // expected viol after the edge
    bit       eb;   // expected busy after the edge
  } vec_t;

  // Reference model: a transfer is "open" after a setup, "stalled" once an
  // enable edge has passed with pready low; counters are plain integers.
  typedef struct {
    bit        open, stalled;
    bit [7:0]  a;
    bit        w;
    bit [2:0]  p;
    bit [31:0] d;
    bit [3:0]  s;
    int        waits;
    bit [6:0]  viol, sticky;
    int        xfer, err, slv;
  } mdl_t;

  mdl_t m_a, m_b, m_zero;

  function automatic bus_t mk(bit sel, bit en, bit wr, bit [7:0] a, bit [31:0] d,
                              bit [3:0] s, bit rdy, bit err);
    bus_t b;
    b.sel = sel; b.en = en; b.wr = wr; b.a = a; b.d = d; b.s = s;
    b.p = 3'd0; b.rdy = rdy; b.err = err;
    return b;
  endfunction

  function automatic int sat(int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic mdl_t mdl_step(mdl_t mi, int max_wait, bit chk_strb, bus_t b, bit c);
    mdl_t     m;
    bit [6:0] v;
    bit       done;
    m = mi; v = '0; done = 1'b0;
    if (b.en && !b.sel) v[4] = 1'b1;
    if (b.sel && !b.en && (!m.open || !m.stalled)) begin
      if (m.open) v[1] = 1'b1;
      m.open = 1'b1; m.stalled = 1'b0; m.waits = 0;
      m.a = b.a; m.w = b.wr; m.p = b.p; m.d = b.d; m.s = b.s;
      if (chk_strb && !b.wr && (b.s != 0)) v[6] = 1'b1;
    end else if (m.open && !b.sel) begin
      v[0] = 1'b1; m.open = 1'b0;
    end else if (m.open && !b.en) begin
      v[1] = 1'b1; m.open = 1'b0;
    end else if (m.open) begin
      if ((b.a != m.a) || (b.wr != m.w) || (chk_strb && (b.p != m.p))) v[2] = 1'b1;
      if (b.wr && ((b.d != m.d) || (chk_strb && (b.s != m.s)))) v[3] = 1'b1;
      if (b.rdy) begin
        done = 1'b1; m.open = 1'b0;
      end else begin
        m.stalled = 1'b1;
        m.waits++;
        if ((max_wait > 0) && (m.waits == max_wait)) v[5] = 1'b1;
      end
    end else if (b.sel && b.en) begin
      v[1] = 1'b1;
    end
    if (c) begin
      m.xfer = 0; m.err = 0; m.slv = 0; m.sticky = '0;
    end else begin
      if (done) m.xfer = sat(m.xfer + 1);
      if (done && b.err) m.slv = sat(m.slv + 1);
      if (v != 0) m.err = sat(m.err + 1);
      m.sticky = m.sticky | v;
    end
    m.viol = v;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a_viol",   32'(viol_a),   32'(m_a.viol));
    chk("a_sticky", 32'(sticky_a), 32'(m_a.sticky));
    chk("a_xfer",   32'(xfer_a),   32'(m_a.xfer));
    chk("a_err",    32'(err_a),    32'(m_a.err));
    chk("a_slverr", 32'(slv_a),    32'(m_a.slv));
    chk("a_busy",   32'(busy_a),   32'(m_a.open));
    chk("b_viol",   32'(viol_b),   32'(m_b.viol));
    chk("b_sticky", 32'(sticky_b), 32'(m_b.sticky));
    chk("b_xfer",   32'(xfer_b),   32'(m_b.xfer));
    chk("b_err",    32'(err_b),    32'(m_b.err));
    chk("b_slverr", 32'(slv_b),    32'(m_b.slv));
    chk("b_busy",   32'(busy_b),   32'(m_b.open));
  endtask

  task automatic drive(input bus_t b, input bit c);
    psel = b.sel; penable = b.en; pwrite = b.wr; paddr = b.a; pwdata = b.d;
    pstrb = b.s; pprot = b.p; pready = b.rdy; pslverr = b.err; clr = c;
  endtask

  // Apply one bus cycle, step the models at the edge, compare just after it.
  task automatic cyc(input bus_t b, input bit c);
    drive(b, c);
    @(posedge pclk);
    m_a = mdl_step(m_a, 4, 1'b1, b, c);
    m_b = mdl_step(m_b, 0, 1'b0, b, c);
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_viol"},   32'({viol_a, viol_b}),     32'd0);
    chk({tag, "_sticky"}, 32'({sticky_a, sticky_b}), 32'd0);
    chk({tag, "_xfer"},   32'({xfer_a, xfer_b}),     32'd0);
    chk({tag, "_err"},    32'({err_a, err_b}),       32'd0);
    chk({tag, "_slverr"}, 32'({slv_a, slv_b}),       32'd0);
    chk({tag, "_busy"},   32'({busy_a, busy_b}),     32'd0);
  endtask

  vec_t tbl[15];
  bus_t idle, rb;
  int   pulses, first_edge;

  initial begin
    idle = mk(0, 0, 0, 8'h00, 32'h0, 4'h0, 0, 0);
    // Write 0x10 with two wait states, then read 0x20 with paddr glitch,
    // then select drop / enable without setup / enable without select.
    tbl[0]  = '{mk(1,0,1,8'h10,32'hDEADBEEF,4'hF,0,0), 7'h00, 1'b1};
    tbl[1]  = '{mk(1,1,1,8'h10,32'hDEADBEEF,4'hF,0,0), 7'h00, 1'b1};
    tbl[2]  = '{mk(1,1,1,8'h10,32'hDEADBEEF,4'hF,0,0), 7'h00, 1'b1};
    tbl[3]  = '{mk(1,1,1,8'h10,32'hDEADBEEF,4'hF,1,0), 7'h00, 1'b0};
    tbl[4]  = '{idle,                                   7'h00, 1'b0};
    tbl[5]  = '{mk(1,0,0,8'h20,32'h0,4'h0,0,0),         7'h00, 1'b1};
    tbl[6]  = '{mk(1,1,0,8'h20,32'h0,4'h0,0,0),         7'h00, 1'b1};
    tbl[7]  = '{mk(1,1,0,8'h24,32'h0,4'h0,0,0),         7'h04, 1'b1};
    tbl[8]  = '{mk(1,1,0,8'h20,32'h0,4'h0,1,0),         7'h00, 1'b0};
    tbl[9]  = '{mk(1,0,0,8'h30,32'h0,4'h0,0,0),         7'h00, 1'b1};
    tbl[10] = '{mk(1,1,0,8'h30,32'h0,4'h0,0,0),         7'h00, 1'b1};
    tbl[11] = '{idle,                                   7'h01, 1'b0};
    tbl[12] = '{mk(1,1,0,8'h30,32'h0,4'h0,0,0),         7'h02, 1'b0};
    tbl[13] = '{mk(0,1,0,8'h30,32'h0,4'h0,0,0),         7'h10, 1'b0};
    tbl[14] = '{idle,                                   7'h00, 1'b0};

    m_zero = '{default: 0};
    m_a = m_zero; m_b = m_zero;
    preset_n = 1'b1;
    drive(idle, 1'b0);
    #2 preset_n = 1'b0;
    @(posedge pclk); @(posedge pclk); #1;
    check_all_zero("reset");
    @(negedge pclk) preset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].b, 1'b0);
      chk($sformatf("vec%0d_viol_a", i), 32'(viol_a), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_viol_b", i), 32'(viol_b), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_busy",   i), 32'(busy_a), 32'(tbl[i].eb));
    end
    chk("tbl_xfer",   32'(xfer_a),   32'd2);
    chk("tbl_err",    32'(err_a),    32'd4);
    chk("tbl_sticky", 32'(sticky_a), 32'h17);

    // Timeout: six stalled enable edges, then pready.
    cyc(mk(1,0,1,8'h50,32'h1234,4'hF,0,0), 1'b0);
    pulses = 0; first_edge = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(mk(1,1,1,8'h50,32'h1234,4'hF,0,0), 1'b0);
      if (viol_a[5]) begin
        pulses++;
        if (first_edge == 0) first_edge = i;
      end
    end
    cyc(mk(1,1,1,8'h50,32'h1234,4'hF,1,0), 1'b0);
    chk("timeout_pulses", 32'(pulses),     32'd1);
    chk("timeout_edge",   32'(first_edge), 32'd4);
    chk("timeout_xfer",   32'(xfer_a),     32'd3);
    chk("timeout_b_off",  32'(sticky_b[5]), 32'd0);

    // Read with non-zero strobes, completing with pslverr.
    cyc(mk(1,0,0,8'h40,32'h0,4'h3,0,0), 1'b0);
    chk("strb_read_a", 32'(viol_a), 32'h40);
    chk("strb_read_b", 32'(viol_b), 32'h00);
    cyc(mk(1,1,0,8'h40,32'h0,4'h3,1,1), 1'b0);
    chk("slverr_a", 32'(slv_a), 32'd1);
    chk("slverr_b", 32'(slv_b), 32'd1);

    // Reset in the middle of ACCESS: outputs drop without a clock edge.
    cyc(mk(1,0,1,8'h60,32'hA5A5,4'hF,0,0), 1'b0);
    cyc(mk(1,1,1,8'h60,32'hA5A5,4'hF,0,0), 1'b0);
    #2 preset_n = 1'b0;
    drive(idle, 1'b0);
    #1;
    check_all_zero("midreset");
    m_a = m_zero; m_b = m_zero;
    @(negedge pclk) preset_n = 1'b1;

    // One clean transfer, then clr in the same cycle as an enable-without-select.
    cyc(mk(1,0,0,8'h70,32'h0,4'h0,0,0), 1'b0);
    cyc(mk(1,1,0,8'h70,32'h0,4'h0,1,0), 1'b0);
    chk("pre_clr_xfer", 32'(xfer_a), 32'd1);
    cyc(mk(0,1,0,8'h70,32'h0,4'h0,0,0), 1'b1);
    chk("clr_viol",   32'(viol_a),   32'h10);
    chk("clr_xfer",   32'(xfer_a),   32'd0);
    chk("clr_err",    32'(err_a),    32'd0);
    chk("clr_sticky", 32'(sticky_a), 32'd0);
    cyc(idle, 1'b0);

    // Random bus activity against the model.
    rb = idle;
    for (int i = 0; i < 3000; i++) begin
      rb.sel = ($urandom_range(0, 7) != 0);
      rb.en  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) rb.wr = ~rb.wr;
      if ($urandom_range(0, 7) == 0) rb.a  = 8'($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) rb.d  = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rb.s  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) rb.p = 3'($urandom_range(0, 7));
      rb.rdy = ($urandom_range(0, 4) < 2);
      rb.err = $urandom_range(0, 3) == 0;
      cyc(rb, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
